mc_hs_controller: RTL
=====================

Name: mc_hs_controller

Overview:
- Parametrised next-generation multi-cycle MIPS controller: main FSM, ALU decode and PC-enable logic.
- Drives the existing multi-cycle datapath.
- Adds a req/ready memory handshake for variable-latency memory, a bus-timeout watchdog, and fault reporting.
- Extends the ISA with bne, andi, ori and slti, and adds an optional retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter
TO_W, 8, width of wait-state watchdog counter
TIMEOUT_CYC, 255, max wait cycles per memory access before fault; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
op  in  6  instr[31:26]
funct  in  6  instr[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested
memwrite  out  1  write strobe, qualified by mem_ready
irwrite, pcen, regwrite, alusrca, iord, memtoreg, regdst, immzext  out  1 each  datapath controls; immzext=1 selects zero-extended immediate
alusrcb, pcsrc  out  2 each  datapath mux selects
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
fault  out  1  sticky fault flag
fault_cause  out  2  01 illegal op, 10 illegal funct, 11 bus timeout
state  out  4  current FSM state (debug)
instret  out  CNT_W  retired instruction count

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset: state=FETCH, fault=0, fault_cause=00, wait counter=0, instret=0.
- All datapath controls are combinational from state, op, funct, zero and mem_ready.

States and transitions:
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite and pcen are asserted only in the cycle mem_ready=1, which also advances to DECODE.
  - Otherwise hold in FETCH.
- DECODE: alusrcb=11, add.
  - Next state by op: lw/sw(100011/101011)->MEMADR; R-type(000000)->RTYPEEX if funct is add/sub/and/or/slt, else FAULT(10).
  - beq(000100)->BEQEX; bne(000101)->BNEEX.
  - addi(001000), andi(001100), ori(001101), slti(001010)->IMMEX.
  - j(000010)->JEX; any other op->FAULT(01).
- MEMADR: alusrca=1, alusrcb=10, add. lw->MEMRD, sw->MEMWR.
- MEMRD: mem_req=1, iord=1. Advance to MEMWB on mem_ready.
- MEMWR: mem_req=1, iord=1, memwrite=mem_ready. Advance to FETCH on mem_ready.
- MEMWB: regwrite=1, regdst=0, memtoreg=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct -> RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH.
- BEQEX / BNEEX: alusrca=1, alusrcb=00, sub, pcsrc=01 -> FETCH.
  - pcen=zero in BEQEX; pcen=~zero in BNEEX.
- IMMEX: alusrca=1, alusrcb=10 -> IMMWB.
  - ALU op: add for addi, and for andi, or for ori, slt for slti.
  - immzext=1 for andi/ori, 0 otherwise.
- IMMWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH.
- JEX: pcsrc=10, pcen=1 -> FETCH.
- FAULT: all strobes 0, mem_req=0. Held until reset.
- FAULT entry latches fault=1 and fault_cause; these outputs are sticky.

Watchdog:
- Wait counter clears on entry to FETCH, MEMRD or MEMWR.
- It increments each cycle mem_req=1 and mem_ready=0.
- If the counter equals TIMEOUT_CYC (nonzero) and mem_ready=0, next state is FAULT(11).
- mem_ready=1 in that same cycle wins: the access completes and no fault is raised.

Reset mid-access: reset overrides everything; any pending write is dropped (memwrite=0 while reset=1).

Optional Feature:
MC_INSTRET_EN
- Defined: instret increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTYPEWB, BEQEX, BNEEX, IMMWB or JEX.
  - Wraps modulo 2^CNT_W.
  - A faulting instruction is not counted.
- Undefined: instret is tied to 0 and no counter flops exist.

Decomposition:
- Package mc_pkg holds:
  - state enum (4-bit: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, IMMEX, IMMWB, JEX, FAULT);
  - opcode and funct constants;
  - alucontrol encodings;
  - 3-bit aluop enum (ADD, SUB, FUNCT, AND, OR, SLT);
  - fault_cause codes.
- Sub-module mc_aludec: (aluop, funct) -> (alucontrol, funct_ok).

Test Plan:
- lw with mem_ready low for 3 cycles in both FETCH and MEMRD:
  - irwrite/pcen pulse exactly once, in the ready cycle;
  - state sequence 0,0,0,0,1,2,3,3,3,3,4,0.
- bne with zero=0 -> pcen=1, pcsrc=01 in BNEEX. bne with zero=1 -> pcen=0. beq is the mirror case.
- ori: IMMEX drives alucontrol=001, immzext=1, alusrcb=10; IMMWB drives regwrite=1, regdst=0.
- op=111111 in DECODE -> FAULT, fault=1, fault_cause=01. Later mem_ready pulses are ignored until reset returns state to FETCH.
- TIMEOUT_CYC=4, mem_ready held 0 in FETCH -> FAULT on the 5th wait cycle, cause 11. Repeat with mem_ready=1 exactly on the 5th cycle -> no fault.
- MC_INSTRET_EN, CNT_W=4: 17 add instructions -> instret=1 (wrap). Reset asserted mid-MEMWR wait -> instret=0, memwrite=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS handshake controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_BNEEX   = 4'd9,
    S_IMMEX   = 4'd10,
    S_IMMWB   = 4'd11,
    S_JEX     = 4'd12,
    S_FAULT   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    AOP_ADD   = 3'd0,
    AOP_SUB   = 3'd1,
    AOP_FUNCT = 3'd2,
    AOP_AND   = 3'd3,
    AOP_OR    = 3'd4,
    AOP_SLT   = 3'd5
  } aluop_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'b00,
    FC_ILL_OP    = 2'b01,
    FC_ILL_FUNCT = 2'b10,
    FC_TIMEOUT   = 2'b11
  } fault_cause_e;

endpackage

// File: rtl/mc_hs_controller_aludec.sv
// ALU decoder: maps (aluop, funct) to the ALU control code and flags unsupported functs.
module mc_aludec
  import mc_pkg::*;
(
  input  aluop_e     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_ok_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    funct_ok_o   = 1'b1;
    case (aluop_i)
      AOP_ADD: alucontrol_o = ALU_ADD;
      AOP_SUB: alucontrol_o = ALU_SUB;
      AOP_AND: alucontrol_o = ALU_AND;
      AOP_OR:  alucontrol_o = ALU_OR;
      AOP_SLT: alucontrol_o = ALU_SLT;
      AOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: funct_ok_o   = 1'b0;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_hs_controller.sv
// Multi-cycle MIPS controller with req/ready memory handshake, watchdog and sticky faults.
// Define MC_INSTRET_EN to build the retired-instruction counter; otherwise instret is 0.
module mc_hs_controller
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TO_W        = 8,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic             immzext,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_e       state_q, state_d;
  logic [TO_W-1:0] wait_q, wait_d;
  logic         fault_q, fault_d;
  fault_cause_e fault_cause_q, fault_cause_d, cause_set;
  aluop_e       aluop;
  logic [2:0]   dec_alucontrol;
  logic         funct_ok;
  logic         memwrite_c;
  logic         wdog_hit;

  mc_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (dec_alucontrol),
    .funct_ok_o   (funct_ok)
  );

  assign wdog_hit = (TIMEOUT_CYC != 0) && !mem_ready && (wait_q == TO_W'(TIMEOUT_CYC));

  // In DECODE the decoder is probed with the funct field for legality while the ALU adds.
  always_comb begin
    aluop = AOP_ADD;
    case (state_q)
      S_DECODE, S_RTYPEEX: aluop = AOP_FUNCT;
      S_BEQEX, S_BNEEX:    aluop = AOP_SUB;
      S_IMMEX: begin
        case (op)
          OP_ANDI: aluop = AOP_AND;
          OP_ORI:  aluop = AOP_OR;
          OP_SLTI: aluop = AOP_SLT;
          default: aluop = AOP_ADD;
        endcase
      end
      default: aluop = AOP_ADD;
    endcase
  end

  assign alucontrol = (state_q == S_DECODE) ? ALU_ADD : dec_alucontrol;

  always_comb begin
    state_d    = state_q;
    cause_set  = FC_NONE;
    mem_req    = 1'b0;
    memwrite_c = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    immzext    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = S_DECODE;
        end else if (wdog_hit) begin
          state_d   = S_FAULT;
          cause_set = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_RTYPEEX;
            end else begin
              state_d   = S_FAULT;
              cause_set = FC_ILL_FUNCT;
            end
          end
          OP_BEQ: state_d = S_BEQEX;
          OP_BNE: state_d = S_BNEEX;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
          OP_J: state_d = S_JEX;
          default: begin
            state_d   = S_FAULT;
            cause_set = FC_ILL_OP;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (wdog_hit) begin
          state_d   = S_FAULT;
          cause_set = FC_TIMEOUT;
        end
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        iord       = 1'b1;
        memwrite_c = mem_ready;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (wdog_hit) begin
          state_d   = S_FAULT;
          cause_set = FC_TIMEOUT;
        end
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        state_d = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca = 1'b1;
        pcsrc   = 2'b01;
        pcen    = (state_q == S_BEQEX) ? zero : !zero;
        state_d = S_FETCH;
      end
      S_IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        immzext = (op == OP_ANDI) || (op == OP_ORI);
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JEX: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  // A write still pending when reset arrives is dropped.
  assign memwrite = memwrite_c && !reset;

  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) &&
        ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR))) begin
      wait_d = '0;
    end else if (mem_req && !mem_ready) begin
      wait_d = wait_q + TO_W'(1);
    end
  end

  always_comb begin
    fault_d       = fault_q;
    fault_cause_d = fault_cause_q;
    if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
      fault_d       = 1'b1;
      fault_cause_d = cause_set;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      fault_q       <= 1'b0;
      fault_cause_q <= FC_NONE;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      fault_q       <= fault_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign state       = state_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

`ifdef MC_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // Count only instructions that complete back into FETCH, never a faulting one.
  always_comb begin
    retire = (state_d == S_FETCH) &&
             (state_q inside {S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_BNEEX, S_IMMWB, S_JEX});
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk) begin
    if (reset) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule
